// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the multiplier issue controller
package mul_pkg;
  typedef enum logic [1:0] {SEW8 = 2'b00, SEW16 = 2'b01, SEW32 = 2'b10} sew_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} ctrl_state_e;
  localparam int MUL_LAT_W = 4;
  typedef struct packed {
    ctrl_state_e      state;
    logic [1:0]       sew;
    logic             pass;
    logic             err;
    logic [31:0]      a1;
    logic [31:0]      b1;
    logic [31:0]      a2;
    logic [31:0]      b2;
    logic [3:0][31:0] w;
  } ctrl_regs_t;
  function automatic logic sew_ok(input logic [1:0] s);
    return s != 2'b11;
  endfunction
endpackage

// File: rtl/mul_lat_counter.sv
// mul_lat_counter: loadable down-counter flagging the cycle its value is 1
module mul_lat_counter
  import mul_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [MUL_LAT_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 hit_o
);
  logic [MUL_LAT_W-1:0] cnt_q, cnt_d;
  // load wins over decrement; stop at zero
  always_comb begin
    cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  // counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign hit_o = cnt_q == MUL_LAT_W'(1);
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: sequences multiply passes and assembles the 128-bit result
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_sew_i,
  input  logic [31:0] req_a1_i,
  input  logic [31:0] req_b1_i,
  input  logic [31:0] req_a2_i,
  input  logic [31:0] req_b2_i,
  output logic        mul_start_o,
  output logic [1:0]  mul_sew_o,
  output logic        mul_count_0_o,
  output logic [31:0] mul_a1_o,
  output logic [31:0] mul_b1_o,
  output logic [31:0] mul_a2_o,
  output logic [31:0] mul_b2_o,
  input  logic [31:0] mul_product_1_i,
  input  logic [31:0] mul_product_2_i,
  input  logic [31:0] mul_product_3_i,
  input  logic [31:0] mul_product_4_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_w0_o,
  output logic [31:0] res_w1_o,
  output logic [31:0] res_w2_o,
  output logic [31:0] res_w3_o,
  output logic        res_err_o
);
  ctrl_regs_t r_q, r_d;
  logic       hit;
  mul_lat_counter u_lat (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (r_q.state == ST_ISSUE),
    .load_val_i (MUL_LAT_W'(MUL_LAT)),
    .dec_i      (r_q.state == ST_WAIT),
    .hit_o      (hit)
  );
  // next-state: accept, issue, capture products per pass, hold result until taken
  always_comb begin
    r_d = r_q;
    case (r_q.state)
      ST_IDLE: if (req_valid_i) begin
        r_d.sew   = req_sew_i;
        r_d.a1    = req_a1_i;
        r_d.b1    = req_b1_i;
        r_d.a2    = req_a2_i;
        r_d.b2    = req_b2_i;
        r_d.pass  = 1'b0;
        r_d.w     = '0;
        r_d.err   = !sew_ok(req_sew_i);
        r_d.state = sew_ok(req_sew_i) ? ST_ISSUE : ST_DONE;
      end
      ST_ISSUE: r_d.state = ST_WAIT;
      ST_WAIT: if (hit) begin
        if (r_q.sew != SEW32) begin
          r_d.w     = {mul_product_4_i, mul_product_3_i, mul_product_2_i, mul_product_1_i};
          r_d.state = ST_DONE;
        end else if (!r_q.pass) begin
          r_d.w[0]  = mul_product_1_i;
          r_d.w[2]  = mul_product_2_i;
          r_d.pass  = 1'b1;
          r_d.state = ST_ISSUE;
        end else begin
          r_d.w[1]  = mul_product_1_i;
          r_d.w[3]  = mul_product_2_i;
          r_d.state = ST_DONE;
        end
      end
      ST_DONE: if (res_ready_i) begin
        r_d.err   = 1'b0;
        r_d.state = ST_IDLE;
      end
      default: r_d.state = ST_IDLE;
    endcase
  end
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk_i) begin
    if (!reset_i) r_q <= '0;
    else r_q <= r_d;
  end
  assign req_ready_o   = r_q.state == ST_IDLE;
  assign mul_start_o   = r_q.state == ST_ISSUE;
  assign mul_count_0_o = r_q.pass;
  assign mul_sew_o     = r_q.sew;
  assign mul_a1_o      = r_q.a1;
  assign mul_b1_o      = r_q.b1;
  assign mul_a2_o      = r_q.a2;
  assign mul_b2_o      = r_q.b2;
  assign res_valid_o   = r_q.state == ST_DONE;
  assign res_err_o     = r_q.err;
  assign res_w0_o      = r_q.w[0];
  assign res_w1_o      = r_q.w[1];
  assign res_w2_o      = r_q.w[2];
  assign res_w3_o      = r_q.w[3];
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: scoreboard bench with a behavioural chunked multiplier
module tb_mul_issue_ctrl;
  import mul_pkg::*;
  localparam int L = 2;
  typedef struct {
    logic [3:0][31:0] w;
    logic             err;
    int               nst;
  } exp_t;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_ready, res_ready = 1;
  logic [1:0] req_sew = 0;
  logic [31:0] req_a1 = 0, req_b1 = 0, req_a2 = 0, req_b2 = 0;
  logic mul_start, mul_count_0, res_valid, res_err;
  logic [1:0] mul_sew;
  logic [31:0] mul_a1, mul_b1, mul_a2, mul_b2, p1, p2, p3, p4, res_w0, res_w1, res_w2, res_w3;
  logic [3:0][31:0] pv, last_w;
  logic [L:1] sr = '0;
  int cyc = 0, nvec = 0, nmis = 0, nst = 0, hs_cyc = 0;
  bit prev_v = 0, prev_s = 0, bp_chk = 0;
  logic [1:0] cur_sew;
  logic [31:0] cur_a1, cur_b2;
  exp_t exp_q[$];
  int due_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mul_issue_ctrl #(.MUL_LAT(L)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sew_i(req_sew), .req_a1_i(req_a1), .req_b1_i(req_b1), .req_a2_i(req_a2), .req_b2_i(req_b2),
    .mul_start_o(mul_start), .mul_sew_o(mul_sew), .mul_count_0_o(mul_count_0),
    .mul_a1_o(mul_a1), .mul_b1_o(mul_b1), .mul_a2_o(mul_a2), .mul_b2_o(mul_b2),
    .mul_product_1_i(p1), .mul_product_2_i(p2), .mul_product_3_i(p3), .mul_product_4_i(p4),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_w0_o(res_w0), .res_w1_o(res_w1), .res_w2_o(res_w2), .res_w3_o(res_w3), .res_err_o(res_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [3:0][31:0] mdl(input logic [1:0] s, input logic c,
                                           input logic [31:0] a1, b1, a2, b2);
    logic [3:0][31:0] r;
    logic [15:0] x1, y1, x2, y2;
    logic [63:0] m1, m2;
    r = '0;
    m1 = 64'(a1) * 64'(b1);
    m2 = 64'(a2) * 64'(b2);
    if (s == 2'b00)
      for (int k = 0; k < 4; k++) begin
        x1 = 16'(a1[8*k+:8]); y1 = 16'(b1[8*k+:8]);
        x2 = 16'(a2[8*k+:8]); y2 = 16'(b2[8*k+:8]);
        r[k] = {x2 * y2, x1 * y1};
      end
    else if (s == 2'b01) begin
      r[0] = 32'(a1[15:0]) * 32'(b1[15:0]);
      r[1] = 32'(a1[31:16]) * 32'(b1[31:16]);
      r[2] = 32'(a2[15:0]) * 32'(b2[15:0]);
      r[3] = 32'(a2[31:16]) * 32'(b2[31:16]);
    end else if (s == 2'b10) begin
      r[0] = c ? m1[63:32] : m1[31:0];
      r[1] = c ? m2[63:32] : m2[31:0];
    end
    return r;
  endfunction
  function automatic logic [3:0][31:0] expw(input logic [1:0] s, input logic [31:0] a1, b1, a2, b2);
    logic [63:0] m1, m2;
    m1 = 64'(a1) * 64'(b1);
    m2 = 64'(a2) * 64'(b2);
    if (s == 2'b11) return '0;
    if (s == 2'b10) return {m2[63:32], m2[31:0], m1[63:32], m1[31:0]};
    return mdl(s, 1'b0, a1, b1, a2, b2);
  endfunction
  always @(posedge clk) sr <= {sr[L-1:1], mul_start};
  always_comb begin
    pv = mdl(mul_sew, mul_count_0, mul_a1, mul_b1, mul_a2, mul_b2);
    {p4, p3, p2, p1} = sr[L] ? pv : {4{32'hDEAD_BEEF}};
  end
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      due_q.delete();
      nst = 0;
      prev_v = 0;
      prev_s = 0;
    end else begin
      if (mul_start) begin
        check("start_gap", 32'(prev_s), 0);
        check("cnt0", 32'(mul_count_0), 32'(nst[0]));
        check("msew", 32'(mul_sew), 32'(cur_sew));
        check("ma1", mul_a1, cur_a1);
        check("mb2", mul_b2, cur_b2);
        nst++;
      end
      if (res_valid) begin
        check("rdy_busy", 32'(req_ready), 0);
        if (!prev_v) begin
          check("due_pend", 32'(due_q.size()), 1);
          if (due_q.size() > 0) check("latency", cyc, due_q.pop_front());
        end
        check("exp_pend", 32'(exp_q.size()), 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          check("w0", res_w0, e.w[0]);
          check("w1", res_w1, e.w[1]);
          check("w2", res_w2, e.w[2]);
          check("w3", res_w3, e.w[3]);
          check("err", 32'(res_err), 32'(e.err));
          if (res_ready) begin
            check("nstart", nst, e.nst);
            last_w = {res_w3, res_w2, res_w1, res_w0};
            hs_cyc = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
      if (req_valid && req_ready) begin
        if (bp_chk) begin
          check("bp_accept", cyc, hs_cyc + 1);
          bp_chk = 0;
        end
        e.w = expw(req_sew, req_a1, req_b1, req_a2, req_b2);
        e.err = req_sew == 2'b11;
        e.nst = req_sew == 2'b11 ? 0 : req_sew == 2'b10 ? 2 : 1;
        exp_q.push_back(e);
        due_q.push_back(cyc + (req_sew == 2'b11 ? 1 : req_sew == 2'b10 ? 2 * (L + 1) + 1 : L + 2));
        cur_sew = req_sew;
        cur_a1 = req_a1;
        cur_b2 = req_b2;
        nst = 0;
      end
      prev_v = res_valid;
      prev_s = mul_start;
    end
  end
  task automatic send(input logic [1:0] s, input logic [31:0] a1, b1, a2, b2);
    bit ok = 0;
    req_sew = s; req_a1 = a1; req_b1 = b1; req_a2 = a2; req_b2 = b2;
    req_valid = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    check("acc_tmo", 32'(ok), 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    check("drain_tmo", 32'(ok), 1);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit seen, ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_start", 32'(mul_start), 0);
    check("rst_w0", res_w0, 0);
    check("rst_err", 32'(res_err), 0);
    check("rst_ma1", mul_a1, 0);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("rst_rdy", 32'(req_ready), 1);
    @(posedge clk); #1;
    send(2'b01, 32'h0004_0008, 32'h0002_0003, 0, 0);
    drain();
    send(2'b10, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'd2);
    drain();
    check("s32_w0", last_w[0], 0);
    check("s32_w1", last_w[1], 1);
    check("s32_w2", last_w[2], 32'hFFFF_FFFE);
    check("s32_w3", last_w[3], 1);
    send(2'b11, $urandom, $urandom, $urandom, $urandom);
    drain();
    for (int i = 0; i < 9; i++) begin
      send(2'(i % 3), $urandom, $urandom, $urandom, $urandom);
      drain();
    end
    res_ready = 0;
    send(2'b01, $urandom, $urandom, $urandom, $urandom);
    bp_chk = 1;
    fork
      send(2'b00, $urandom, $urandom, $urandom, $urandom);
      begin
        ok = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (res_valid) begin ok = 1; break; end
        end
        check("bp_tmo", 32'(ok), 1);
        repeat (5) begin
          @(negedge clk);
          check("bp_hold", 32'(res_valid), 1);
        end
        @(posedge clk); #1 res_ready = 1;
      end
    join
    drain();
    check("bp_done", 32'(bp_chk), 0);
    send(2'b10, $urandom, $urandom, $urandom, $urandom);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("rmid_rdy", 32'(req_ready), 1);
    check("rmid_start", 32'(mul_start), 0);
    check("rmid_valid", 32'(res_valid), 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen |= res_valid | mul_start;
    end
    check("rmid_quiet", 32'(seen), 0);
    @(posedge clk); #1;
    send(2'b01, $urandom, $urandom, $urandom, $urandom);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
